// File: rtl/score_keeper.sv
// Multi-player BCD score keeper with a PLAY/WON match FSM, latency 1, no backpressure.
// Optional SCORE_KEEPER_DEUCE_EN: a winner must also lead every other player by 2 points.
module score_keeper #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 11
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NUM_PLAYERS-1:0]                hit,
  input  logic                                  clear,
  output logic [NUM_PLAYERS*DIGITS*4-1:0]       scoreboard,
  output logic                                  game_over,
  output logic [((NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1)-1:0] winner_id,
  output logic                                  point_scored
);

  localparam int WW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1;
  localparam int SW = DIGITS * 4;
  localparam int CW = $clog2(10 ** DIGITS);
  localparam logic [CW-1:0] MAX_C = CW'((10 ** DIGITS) - 1);
  localparam logic [CW-1:0] WIN_C = CW'(WIN_SCORE);

  localparam logic [0:0] ST_PLAY = 1'b0;
  localparam logic [0:0] ST_WON  = 1'b1;

  logic [0:0]             r_state;
  logic [CW-1:0]          r_bin [NUM_PLAYERS];
  logic [SW-1:0]          r_bcd [NUM_PLAYERS];
  logic [WW-1:0]          r_winner;
  logic                   r_point;

  logic [CW-1:0]          w_bin_nxt [NUM_PLAYERS];
  logic [SW-1:0]          w_bcd_nxt [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] w_inc;
  logic [NUM_PLAYERS-1:0] w_ok;
  logic                   w_win_any;
  logic [WW-1:0]          w_win_id;

  // Ripple BCD increment; the saturation guard means an all-nines value never arrives here.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic          c;
    logic [3:0]    d;
    logic [SW-1:0] res;
    res = v;
    c   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[k*4 +: 4];
      if (c) begin
        if (d == 4'd9) begin
          res[k*4 +: 4] = 4'd0;
        end else begin
          res[k*4 +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    w_bin_nxt = r_bin;
    w_bcd_nxt = r_bcd;
    w_inc     = '0;
    if (r_state == ST_PLAY) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (hit[i] && (r_bin[i] != MAX_C)) begin
          w_inc[i]     = 1'b1;
          w_bin_nxt[i] = r_bin[i] + CW'(1);
          w_bcd_nxt[i] = bcd_inc(r_bcd[i]);
        end
      end
    end
  end

  // Win test runs on the post-increment counts so the FSM flips on the same edge.
`ifdef SCORE_KEEPER_DEUCE_EN
  localparam logic [CW:0] LEAD_C = (CW+1)'(2);
  always_comb begin
    w_ok = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_ok[i] = (w_bin_nxt[i] >= WIN_C);
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if ((j != i) && ({1'b0, w_bin_nxt[i]} < ({1'b0, w_bin_nxt[j]} + LEAD_C))) begin
          w_ok[i] = 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    w_ok = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      w_ok[i] = (w_bin_nxt[i] >= WIN_C);
    end
  end
`endif

  always_comb begin
    w_win_any = 1'b0;
    w_win_id  = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (w_ok[i]) begin
        w_win_any = 1'b1;
        w_win_id  = WW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_PLAY;
      r_winner <= '0;
      r_point  <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_bin[i] <= '0;
        r_bcd[i] <= '0;
      end
    end else if (clear) begin
      r_state  <= ST_PLAY;
      r_winner <= '0;
      r_point  <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        r_bin[i] <= '0;
        r_bcd[i] <= '0;
      end
    end else begin
      r_bin   <= w_bin_nxt;
      r_bcd   <= w_bcd_nxt;
      r_point <= |w_inc;
      if ((r_state == ST_PLAY) && w_win_any) begin
        r_state  <= ST_WON;
        r_winner <= w_win_id;
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_sb
    assign scoreboard[g*SW +: SW] = r_bcd[g];
  end

  assign game_over    = (r_state == ST_WON);
  assign winner_id    = r_winner;
  assign point_scored = r_point;

endmodule

// File: tb/tb_score_keeper.sv
// Directed-vector bench for score_keeper: default 2-player instance plus a 3-player 1-digit instance.
module tb_score_keeper;

  logic        clk;
  logic        resetn;
  logic [1:0]  hit_a;
  logic        clear_a;
  logic [15:0] sb_a;
  logic        go_a;
  logic [0:0]  wid_a;
  logic        ps_a;

  logic [2:0]  hit_b;
  logic        clear_b;
  logic [11:0] sb_b;
  logic        go_b;
  logic [1:0]  wid_b;
  logic        ps_b;

  int n_vec;
  int n_miss;
  int pulses;

  score_keeper u_dut_a (
    .clk(clk), .resetn(resetn), .hit(hit_a), .clear(clear_a),
    .scoreboard(sb_a), .game_over(go_a), .winner_id(wid_a), .point_scored(ps_a)
  );

  score_keeper #(.NUM_PLAYERS(3), .DIGITS(1), .WIN_SCORE(9)) u_dut_b (
    .clk(clk), .resetn(resetn), .hit(hit_b), .clear(clear_b),
    .scoreboard(sb_b), .game_over(go_b), .winner_id(wid_b), .point_scored(ps_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; pulses = 0;
    resetn = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
    hit_a = 2'b00; hit_b = 3'b000;
    #12;
    check("rst_sb", sb_a, 32'h0);
    check("rst_go", go_a, 32'h0);
    check("rst_wid", wid_a, 32'h0);
    check("rst_ps", ps_a, 32'h0);
    check("rst_sb_b", sb_b, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Ten single-cycle awards to player 0, crossing the 9->10 digit carry
    for (int k = 0; k < 10; k++) begin
      hit_a = 2'b01;
      tick();
      pulses += ps_a;
      if (k == 0) check("lat1_sb", sb_a, 32'h0001);
      if (k == 8) check("nine_sb", sb_a, 32'h0009);
    end
    hit_a = 2'b00;
    tick();
    pulses += ps_a;
    check("ten_sb", sb_a, 32'h0010);
    check("ten_go", go_a, 32'h0);
    check("ten_pulses", pulses, 32'd10);
    check("idle_ps", ps_a, 32'h0);

    // Player 1 to 10, then the winning point
    hit_a = 2'b10;
    for (int k = 0; k < 10; k++) tick();
    check("p1ten_sb", sb_a, 32'h1010);
    check("p1ten_go", go_a, 32'h0);
    tick();
`ifdef SCORE_KEEPER_DEUCE_EN
    check("d_1110_go", go_a, 32'h0);
    tick();
    hit_a = 2'b00;
    check("d_win_sb", sb_a, 32'h1210);
    check("d_win_go", go_a, 32'h1);
    check("d_win_wid", wid_a, 32'h1);
    hit_a = 2'b11;
    tick(); tick();
    check("d_hold_sb", sb_a, 32'h1210);
`else
    hit_a = 2'b00;
    check("win_sb", sb_a, 32'h1110);
    check("win_go", go_a, 32'h1);
    check("win_wid", wid_a, 32'h1);
    check("win_ps", ps_a, 32'h1);
    hit_a = 2'b11;
    tick(); tick();
    check("hold_sb", sb_a, 32'h1110);
`endif
    check("hold_go", go_a, 32'h1);
    check("hold_wid", wid_a, 32'h1);
    check("hold_ps", ps_a, 32'h0);

    // clear wins over hit while in WON
    clear_a = 1'b1; hit_a = 2'b11;
    tick();
    clear_a = 1'b0; hit_a = 2'b00;
    check("clr_sb", sb_a, 32'h0);
    check("clr_go", go_a, 32'h0);
    check("clr_wid", wid_a, 32'h0);
    check("clr_ps", ps_a, 32'h0);
    hit_a = 2'b01;
    tick();
    hit_a = 2'b00;
    check("replay_sb", sb_a, 32'h0001);
    check("replay_ps", ps_a, 32'h1);

    // clear wins over hit while in PLAY
    clear_a = 1'b1; hit_a = 2'b01;
    tick();
    clear_a = 1'b0; hit_a = 2'b00;
    check("clrplay_sb", sb_a, 32'h0);
    check("clrplay_ps", ps_a, 32'h0);

    // Simultaneous hits to 10-10, then a tying pair of points
    hit_a = 2'b11;
    for (int k = 0; k < 10; k++) tick();
    check("tie_sb", sb_a, 32'h1010);
    tick();
`ifdef SCORE_KEEPER_DEUCE_EN
    check("d_tie_go", go_a, 32'h0);
    hit_a = 2'b01;
    tick();
    check("d_adv_go", go_a, 32'h0);
    tick();
    hit_a = 2'b00;
    check("d_lead_sb", sb_a, 32'h1113);
    check("d_lead_go", go_a, 32'h1);
    check("d_lead_wid", wid_a, 32'h0);
`else
    hit_a = 2'b00;
    check("tie11_sb", sb_a, 32'h1111);
    check("tie11_go", go_a, 32'h1);
    check("tie11_wid", wid_a, 32'h0);
`endif

    // Three players, one digit: players 1 and 2 reach 9 together
    hit_b = 3'b111;
    for (int k = 0; k < 8; k++) tick();
    check("b888_sb", sb_b, 32'h888);
    check("b888_go", go_b, 32'h0);
    hit_b = 3'b110;
    tick();
    check("b998_sb", sb_b, 32'h998);
`ifdef SCORE_KEEPER_DEUCE_EN
    check("d_b998_go", go_b, 32'h0);
    hit_b = 3'b111;
    tick();
    check("d_bsat_sb", sb_b, 32'h999);
    check("d_bsat_ps", ps_b, 32'h1);
    tick();
    check("d_bsat2_sb", sb_b, 32'h999);
    check("d_bsat2_ps", ps_b, 32'h0);
    check("d_bsat2_go", go_b, 32'h0);
`else
    check("b_win_go", go_b, 32'h1);
    check("b_win_wid", wid_b, 32'h1);
    hit_b = 3'b111;
    tick();
    check("b_hold_sb", sb_b, 32'h998);
    check("b_hold_ps", ps_b, 32'h0);
`endif

    // Asynchronous reset in the middle of a cycle
    #2;
    resetn = 1'b0;
    #1;
    check("arst_sb_a", sb_a, 32'h0);
    check("arst_go_a", go_a, 32'h0);
    check("arst_sb_b", sb_b, 32'h0);
    check("arst_go_b", go_b, 32'h0);
    check("arst_wid_b", wid_b, 32'h0);
    check("arst_ps_b", ps_b, 32'h0);
    hit_b = 3'b000;
    @(negedge clk);
    resetn = 1'b1;
    hit_a = 2'b10;
    tick();
    hit_a = 2'b00;
    check("post_rst_sb", sb_a, 32'h0100);
    check("post_rst_go", go_a, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of player channels; legal range 2..8.
REQ-002 Parameter DIGITS, default 2, BCD digits per player score; legal range 1..4.
REQ-003 Parameter WIN_SCORE, default 11, points needed to win; legal range 1..(10^DIGITS - 1).
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port resetn, input, 1, asynchronous active-low reset.
REQ-006 Port hit, input, NUM_PLAYERS, bit i high for one cycle awards player i one point.
REQ-007 Port clear, input, 1, synchronous new-match request.
REQ-008 Port scoreboard, output, NUM_PLAYERS*DIGITS*4, packed BCD scores; player 0 occupies the least significant DIGITS*4 bits, player i the next field above player i-1.
REQ-009 Port game_over, output, 1, high while a winner is latched.
REQ-010 Port winner_id, output, max(1,clog2(NUM_PLAYERS)), index of the winning player; valid only while game_over is high.
REQ-011 Port point_scored, output, 1, registered pulse; high for one cycle after any score field changes.

Function
REQ-012 The FSM SHALL have exactly two states: PLAY and WON.
REQ-013 In PLAY, each cycle with hit[i]=1 SHALL increment player i's score by one, visible on scoreboard the following cycle (latency 1).
REQ-014 A hit held high for k cycles SHALL award k points; there is no edge detection.
REQ-015 Increments SHALL be BCD: a digit at 9 wraps to 0 and carries into the next digit.
REQ-016 A score at 10^DIGITS - 1 SHALL saturate; further hits leave it unchanged and do not pulse point_scored.
REQ-017 Simultaneous hits on several players in one cycle SHALL all be applied in that cycle.
REQ-018 The block SHALL evaluate the win condition on the updated scores in the same edge; the FSM SHALL then move PLAY -> WON, with game_over and winner_id valid in the cycle the new scores appear.
REQ-019 If several players satisfy the win condition in the same cycle, the lowest index SHALL win.
REQ-020 In WON, hit SHALL be ignored, and scores, winner_id and game_over SHALL hold.
REQ-021 clear=1 in either state SHALL zero all scores, drive game_over low, set winner_id to 0, and enter PLAY on the next edge.
REQ-022 clear SHALL take priority over hit in the same cycle; no points are awarded in that cycle.
REQ-023 point_scored SHALL be high in the cycle after an edge at which at least one score field changed, and low after a clear.
REQ-024 Internal binary shadow counts MAY be kept for comparison, but scoreboard SHALL always equal their BCD representation.

Reset
REQ-025 While resetn=0, the block SHALL asynchronously hold all scores at 0, state PLAY, game_over 0, winner_id 0 and point_scored 0.
REQ-026 Reset deasserted in mid-match SHALL restart from the all-zero PLAY condition; no score survives reset.

Configuration
REQ-027 Macro SCORE_KEEPER_DEUCE_EN, when defined, SHALL make the win condition: score >= WIN_SCORE AND the player leads every other player by at least 2.
REQ-028 When SCORE_KEEPER_DEUCE_EN is undefined, the win condition SHALL be: score >= WIN_SCORE only; no deuce logic is synthesised.
REQ-029 With deuce enabled and every contender saturated, no win SHALL occur; the block stays in PLAY until clear.

Verification
REQ-030 Reset, then hit=2'b01 for 10 cycles (defaults) -> scoreboard=16'h0010, game_over=0, point_scored pulsed 10 times.
REQ-031 Defaults, deuce off; player 1 reaches 11 while player 0 has 10 -> scoreboard=16'h1110, game_over=1, winner_id=1; further hits leave scoreboard unchanged.
REQ-032 Deuce on; scores 10-10, then player 0 scores twice -> after 11-10 still PLAY; after 12-10, game_over=1 and winner_id=0.
REQ-033 Scores 10-10 with deuce off; hit=2'b11 in one cycle -> 11-11, game_over=1, winner_id=0 (lowest index).
REQ-034 clear asserted together with hit=2'b11 during WON -> next cycle scoreboard=0, game_over=0, state PLAY, point_scored=0.
REQ-035 DIGITS=1, WIN_SCORE=9, deuce on, score 9-9 plus extra hits -> both saturate at 9, no win; resetn pulsed low mid-cycle -> all outputs 0 immediately.
